// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-order feature map.
// Optional MAXPOOL_RELU_EN fuses a ReLU onto the pooled output.
module maxpool2x2_stream #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMG_W  = 24,
  parameter int unsigned IMG_H  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned COL_W    = $clog2(IMG_W);
  localparam int unsigned ROW_W    = $clog2(IMG_H);
  localparam int unsigned LB_DEPTH = IMG_W / 2;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0] h_reg_q, h_reg_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] linebuf_q [LB_DEPTH];
  logic [LB_AW-1:0]  lb_idx;
  logic [DATA_W-1:0] lb_rd;
  logic              lb_we;

  logic              in_hs;
  logic              out_hs;
  logic              last_col;
  logic              last_row;
  logic signed [DATA_W-1:0] in_s;
  logic signed [DATA_W-1:0] h_s;
  logic signed [DATA_W-1:0] lb_s;
  logic signed [DATA_W-1:0] h_max;
  logic signed [DATA_W-1:0] pool;

  // Output stage: optional ReLU, width preserved exactly.
  function automatic logic [DATA_W-1:0] post_op(input logic signed [DATA_W-1:0] v);
`ifdef MAXPOOL_RELU_EN
    return v[DATA_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Upstream may advance in the same cycle the output register drains.
  assign in_ready = (state_q == S_RUN) && !(out_valid_q && !out_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;
  assign last_col = (col_q == COL_W'(IMG_W - 1));
  assign last_row = (row_q == ROW_W'(IMG_H - 1));
  assign lb_idx   = LB_AW'(col_q >> 1);
  assign lb_rd    = linebuf_q[lb_idx];

  assign in_s  = $signed(in_data);
  assign h_s   = $signed(h_reg_q);
  assign lb_s  = $signed(lb_rd);
  assign h_max = (in_s > h_s) ? in_s : h_s;
  assign pool  = (lb_s > h_max) ? lb_s : h_max;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    h_reg_d     = h_reg_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    lb_we       = 1'b0;
    done_d      = 1'b0;

    if (out_hs) out_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_RUN: begin
        if (in_hs) begin
          if (!col_q[0]) begin
            h_reg_d = in_data;
          end else if (!row_q[0]) begin
            lb_we = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = post_op(pool);
          end
          if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + ROW_W'(1);
            if (last_row) state_d = S_FLUSH;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_FLUSH: begin
        // Leave as soon as the final pooled pixel is taken.
        if (!out_valid_d) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || done_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      h_reg_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      h_reg_q     <= h_reg_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Even-row horizontal maxima; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf_q[lb_idx] <= h_max;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
